// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing constants for the commit unit.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX   = 4;
    localparam int RETIRE_W  = 3;
    // Kept in step with the architectural register-file package.
    localparam int AR_SIZE   = 7;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               dest_en;
        logic [AR_SIZE-1:0] rd;
        logic [DATA_W-1:0]  data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational retire selection over the three oldest ROB entries.
// Slot 0 is the oldest (head). Produces retire count and per-slot
// register-file write ports with duplicate-rd suppression.
module rob_retire_sel
    import rob_pkg::*;
(
    input  rob_entry_t [RETIRE_W-1:0]              head_ent,
    output logic [1:0]                             ret_cnt,
    output logic [RETIRE_W-1:0]                    wr_en,
    output logic [RETIRE_W-1:0][AR_SIZE-1:0]       wr_addr,
    output logic [RETIRE_W-1:0][DATA_W-1:0]        wr_data
);

    logic [RETIRE_W-1:0] ready;
    logic [RETIRE_W-1:0] take;
    logic [RETIRE_W-1:0] raw_en;

    // Longest in-order prefix of completed entries, then per-slot enables where
    // a younger retiring write to the same rd masks every older one.
    always_comb begin
        ready   = '0;
        take    = '0;
        raw_en  = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            ready[i] = head_ent[i].valid && head_ent[i].done;
        end
        take[0] = ready[0];
        for (int i = 1; i < RETIRE_W; i++) begin
            take[i] = take[i-1] && ready[i];
        end
        ret_cnt = 2'(take[0]) + 2'(take[1]) + 2'(take[2]);
        for (int i = 0; i < RETIRE_W; i++) begin
            raw_en[i]  = take[i] && head_ent[i].dest_en && (head_ent[i].rd != '0);
            wr_addr[i] = head_ent[i].rd;
            wr_data[i] = head_ent[i].data;
        end
        for (int i = 0; i < RETIRE_W; i++) begin
            wr_en[i] = raw_en[i];
            for (int j = i + 1; j < RETIRE_W; j++) begin
                if (raw_en[j] && (head_ent[j].rd == head_ent[i].rd)) begin
                    wr_en[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// In-order commit unit: 16-entry reorder buffer with single-entry dispatch
// allocation, two out-of-order completion ports and up to three in-order
// retires per cycle feeding the register-file write ports.
module rob_commit #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int ROB_IDX   = rob_pkg::ROB_IDX,
    parameter int AR_SIZE   = rob_pkg::AR_SIZE,
    parameter int DATA_W    = rob_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                alloc_valid,
    input  logic                alloc_dest_en,
    input  logic [AR_SIZE-1:0]  alloc_rd,
    output logic                alloc_ready,
    output logic [ROB_IDX-1:0]  alloc_idx,
    input  logic                cmpl0_valid,
    input  logic [ROB_IDX-1:0]  cmpl0_idx,
    input  logic [DATA_W-1:0]   cmpl0_data,
    input  logic                cmpl1_valid,
    input  logic [ROB_IDX-1:0]  cmpl1_idx,
    input  logic [DATA_W-1:0]   cmpl1_data,
    output logic                ret_wr_en1,
    output logic [AR_SIZE-1:0]  ret_wr_addr1,
    output logic [DATA_W-1:0]   ret_wr_data1,
    output logic                ret_wr_en2,
    output logic [AR_SIZE-1:0]  ret_wr_addr2,
    output logic [DATA_W-1:0]   ret_wr_data2,
    output logic                ret_wr_en3,
    output logic [AR_SIZE-1:0]  ret_wr_addr3,
    output logic [DATA_W-1:0]   ret_wr_data3,
    output logic [1:0]          retire_count,
    output logic [ROB_IDX:0]    rob_count,
    output logic                rob_empty
);

    import rob_pkg::RETIRE_W;
    import rob_pkg::rob_entry_t;

    rob_entry_t                          ent_q [ROB_DEPTH];
    rob_entry_t                          ent_d [ROB_DEPTH];
    logic [ROB_IDX-1:0]                  head_q, head_d;
    logic [ROB_IDX-1:0]                  tail_q, tail_d;
    logic [ROB_IDX:0]                    count_q, count_d;
    logic [RETIRE_W-1:0]                 ret_en_q, ret_en_d;
    logic [RETIRE_W-1:0][AR_SIZE-1:0]    ret_addr_q, ret_addr_d;
    logic [RETIRE_W-1:0][DATA_W-1:0]     ret_data_q, ret_data_d;
    logic [1:0]                          ret_cnt_q, ret_cnt_d;

    rob_entry_t [RETIRE_W-1:0]           head_ent;
    logic [1:0]                          sel_cnt;
    logic [RETIRE_W-1:0]                 sel_en;
    logic [RETIRE_W-1:0][AR_SIZE-1:0]    sel_addr;
    logic [RETIRE_W-1:0][DATA_W-1:0]     sel_data;
    logic                                alloc_fire;

    // Full is judged on registered occupancy only, so a same-cycle retire
    // never opens a slot for that cycle's allocation.
    assign alloc_ready = (count_q != (ROB_IDX+1)'(ROB_DEPTH));
    assign alloc_idx   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Gather the three oldest entries (wrapping) for retire selection.
    always_comb begin
        for (int i = 0; i < RETIRE_W; i++) begin
            head_ent[i] = ent_q[head_q + ROB_IDX'(i)];
        end
    end

    rob_retire_sel u_sel (
        .head_ent (head_ent),
        .ret_cnt  (sel_cnt),
        .wr_en    (sel_en),
        .wr_addr  (sel_addr),
        .wr_data  (sel_data)
    );

    // Next-state: flush dominates; otherwise completion, retire, then alloc.
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ret_en_d   = sel_en;
        ret_addr_d = sel_addr;
        ret_data_d = sel_data;
        ret_cnt_d  = sel_cnt;
        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            ret_en_d   = '0;
            ret_cnt_d  = '0;
            ret_addr_d = ret_addr_q;
            ret_data_d = ret_data_q;
        end else begin
            // Port 1 is applied second so it wins a same-index collision.
            if (cmpl0_valid && ent_q[cmpl0_idx].valid && !ent_q[cmpl0_idx].done) begin
                ent_d[cmpl0_idx].done = 1'b1;
                ent_d[cmpl0_idx].data = cmpl0_data;
            end
            if (cmpl1_valid && ent_q[cmpl1_idx].valid && !ent_q[cmpl1_idx].done) begin
                ent_d[cmpl1_idx].done = 1'b1;
                ent_d[cmpl1_idx].data = cmpl1_data;
            end
            for (int i = 0; i < RETIRE_W; i++) begin
                if (i < int'(sel_cnt)) begin
                    ent_d[head_q + ROB_IDX'(i)] = '0;
                end
            end
            head_d = head_q + ROB_IDX'(sel_cnt);
            if (alloc_fire) begin
                ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, dest_en: alloc_dest_en,
                                  rd: alloc_rd, data: '0};
                tail_d = tail_q + ROB_IDX'(1);
            end
            count_d = count_q + (ROB_IDX+1)'(alloc_fire) - (ROB_IDX+1)'(sel_cnt);
        end
    end

    // State and retire-port registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ret_en_q   <= '0;
            ret_addr_q <= '0;
            ret_data_q <= '0;
            ret_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ret_en_q   <= ret_en_d;
            ret_addr_q <= ret_addr_d;
            ret_data_q <= ret_data_d;
            ret_cnt_q  <= ret_cnt_d;
        end
    end

    assign ret_wr_en1   = ret_en_q[0];
    assign ret_wr_en2   = ret_en_q[1];
    assign ret_wr_en3   = ret_en_q[2];
    assign ret_wr_addr1 = ret_addr_q[0];
    assign ret_wr_addr2 = ret_addr_q[1];
    assign ret_wr_addr3 = ret_addr_q[2];
    assign ret_wr_data1 = ret_data_q[0];
    assign ret_wr_data2 = ret_data_q[1];
    assign ret_wr_data3 = ret_data_q[2];
    assign retire_count = ret_cnt_q;
    assign rob_count    = count_q;
    assign rob_empty    = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit.
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_dest_en;
    logic [6:0]  alloc_rd;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic        cmpl0_valid, cmpl1_valid;
    logic [3:0]  cmpl0_idx, cmpl1_idx;
    logic [31:0] cmpl0_data, cmpl1_data;
    logic        ret_wr_en1, ret_wr_en2, ret_wr_en3;
    logic [6:0]  ret_wr_addr1, ret_wr_addr2, ret_wr_addr3;
    logic [31:0] ret_wr_data1, ret_wr_data2, ret_wr_data3;
    logic [1:0]  retire_count;
    logic [4:0]  rob_count;
    logic        rob_empty;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dest_en(alloc_dest_en), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl0_valid(cmpl0_valid), .cmpl0_idx(cmpl0_idx), .cmpl0_data(cmpl0_data),
        .cmpl1_valid(cmpl1_valid), .cmpl1_idx(cmpl1_idx), .cmpl1_data(cmpl1_data),
        .ret_wr_en1(ret_wr_en1), .ret_wr_addr1(ret_wr_addr1), .ret_wr_data1(ret_wr_data1),
        .ret_wr_en2(ret_wr_en2), .ret_wr_addr2(ret_wr_addr2), .ret_wr_data2(ret_wr_data2),
        .ret_wr_en3(ret_wr_en3), .ret_wr_addr3(ret_wr_addr3), .ret_wr_data3(ret_wr_data3),
        .retire_count(retire_count), .rob_count(rob_count), .rob_empty(rob_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_dest_en = 0; alloc_rd = '0;
        cmpl0_valid = 0; cmpl0_idx = '0; cmpl0_data = '0;
        cmpl1_valid = 0; cmpl1_idx = '0; cmpl1_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        tick(); tick();
        rstn = 1;
    endtask

    task automatic do_alloc(input logic de, input logic [6:0] rd);
        alloc_valid = 1; alloc_dest_en = de; alloc_rd = rd;
        tick();
        alloc_valid = 0;
    endtask

    // Drive one cycle of completions; v0/v1 enable each port.
    task automatic do_cmpl(input logic v0, input logic [3:0] i0, input logic [31:0] d0,
                           input logic v1, input logic [3:0] i1, input logic [31:0] d1);
        cmpl0_valid = v0; cmpl0_idx = i0; cmpl0_data = d0;
        cmpl1_valid = v1; cmpl1_idx = i1; cmpl1_data = d1;
        tick();
        cmpl0_valid = 0; cmpl1_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({alloc_ready, alloc_idx, retire_count, rob_count, rob_empty} !== {1'b1, 4'd0, 2'd0, 5'd0, 1'b1})
            $display("FAIL reset_status got rdy=%b idx=%0d rc=%0d cnt=%0d emp=%b",
                     alloc_ready, alloc_idx, retire_count, rob_count, rob_empty);
        else n_pass++;
        n_total++;
        if ({ret_wr_en1, ret_wr_en2, ret_wr_en3} !== 3'b000)
            $display("FAIL reset_en got %b want 000", {ret_wr_en1, ret_wr_en2, ret_wr_en3});
        else n_pass++;
        n_total++;
        if ({ret_wr_addr1, ret_wr_addr2, ret_wr_addr3, ret_wr_data1, ret_wr_data2, ret_wr_data3} !== '0)
            $display("FAIL reset_addr_data got a=%0d,%0d,%0d d=%0h,%0h,%0h want all 0",
                     ret_wr_addr1, ret_wr_addr2, ret_wr_addr3, ret_wr_data1, ret_wr_data2, ret_wr_data3);
        else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        do_alloc(1, 7'd5); do_alloc(1, 7'd6); do_alloc(1, 7'd7);
        do_cmpl(1, 4'd2, 32'hA, 0, 4'd0, 32'h0);
        do_cmpl(1, 4'd0, 32'hB, 1, 4'd1, 32'hC);
        n_total++;
        if (retire_count !== 2'd0 || rob_count !== 5'd3)
            $display("FAIL ooo_no_early_retire got rc=%0d cnt=%0d want 0/3", retire_count, rob_count);
        else n_pass++;
        tick();
        n_total++;
        if (retire_count !== 2'd3 || {ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b111)
            $display("FAIL ooo_retire got rc=%0d en=%b want 3/111", retire_count, {ret_wr_en3, ret_wr_en2, ret_wr_en1});
        else n_pass++;
        n_total++;
        if ({ret_wr_addr1, ret_wr_addr2, ret_wr_addr3} !== {7'd5, 7'd6, 7'd7} ||
            {ret_wr_data1, ret_wr_data2, ret_wr_data3} !== {32'hB, 32'hC, 32'hA})
            $display("FAIL ooo_writes got %0d<-%0h %0d<-%0h %0d<-%0h want 5<-b 6<-c 7<-a",
                     ret_wr_addr1, ret_wr_data1, ret_wr_addr2, ret_wr_data2, ret_wr_addr3, ret_wr_data3);
        else n_pass++;
        n_total++;
        if (rob_empty !== 1'b1 || rob_count !== 5'd0)
            $display("FAIL ooo_empty got emp=%b cnt=%0d want 1/0", rob_empty, rob_count);
        else n_pass++;
        tick();
        n_total++;
        if (retire_count !== 2'd0 || {ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b000)
            $display("FAIL ooo_one_cycle got rc=%0d en=%b want 0/000", retire_count, {ret_wr_en3, ret_wr_en2, ret_wr_en1});
        else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(1, 7'(i + 1));
        n_total++;
        if (alloc_ready !== 1'b0 || rob_count !== 5'd16 || alloc_idx !== 4'd0)
            $display("FAIL full_status got rdy=%b cnt=%0d idx=%0d want 0/16/0", alloc_ready, rob_count, alloc_idx);
        else n_pass++;
        do_alloc(1, 7'd99);
        n_total++;
        if (rob_count !== 5'd16 || alloc_idx !== 4'd0)
            $display("FAIL full_reject got cnt=%0d idx=%0d want 16/0", rob_count, alloc_idx);
        else n_pass++;
        do_cmpl(1, 4'd0, 32'h55, 0, 4'd0, 32'h0);
        n_total++;
        if (alloc_ready !== 1'b0)
            $display("FAIL full_before_retire got rdy=%b want 0", alloc_ready);
        else n_pass++;
        tick();
        n_total++;
        if (retire_count !== 2'd1 || ret_wr_en1 !== 1'b1 || ret_wr_addr1 !== 7'd1 || ret_wr_data1 !== 32'h55)
            $display("FAIL full_head_retire got rc=%0d en1=%b a1=%0d d1=%0h want 1/1/1/55",
                     retire_count, ret_wr_en1, ret_wr_addr1, ret_wr_data1);
        else n_pass++;
        n_total++;
        if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0 || rob_count !== 5'd15)
            $display("FAIL full_wrap got rdy=%b idx=%0d cnt=%0d want 1/0/15", alloc_ready, alloc_idx, rob_count);
        else n_pass++;
        do_alloc(1, 7'd20);
        n_total++;
        if (alloc_idx !== 4'd1 || rob_count !== 5'd16 || alloc_ready !== 1'b0)
            $display("FAIL wrap_alloc got idx=%0d cnt=%0d rdy=%b want 1/16/0", alloc_idx, rob_count, alloc_ready);
        else n_pass++;
    endtask

    task automatic test_same_rd();
        do_reset();
        do_alloc(1, 7'd3); do_alloc(1, 7'd3); do_alloc(1, 7'd3);
        do_cmpl(1, 4'd2, 32'd3, 1, 4'd1, 32'd2);
        do_cmpl(1, 4'd0, 32'd1, 0, 4'd0, 32'd0);
        tick();
        n_total++;
        if (retire_count !== 2'd3 || {ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b100 ||
            ret_wr_addr3 !== 7'd3 || ret_wr_data3 !== 32'd3)
            $display("FAIL same_rd got rc=%0d en=%b a3=%0d d3=%0d want 3/100/3/3",
                     retire_count, {ret_wr_en3, ret_wr_en2, ret_wr_en1}, ret_wr_addr3, ret_wr_data3);
        else n_pass++;
    endtask

    task automatic test_no_dest();
        do_reset();
        do_alloc(0, 7'd9); do_alloc(1, 7'd0);
        do_cmpl(1, 4'd0, 32'h77, 1, 4'd1, 32'h88);
        tick();
        n_total++;
        if (retire_count !== 2'd2 || {ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b000 || rob_count !== 5'd0)
            $display("FAIL no_dest got rc=%0d en=%b cnt=%0d want 2/000/0",
                     retire_count, {ret_wr_en3, ret_wr_en2, ret_wr_en1}, rob_count);
        else n_pass++;
    endtask

    task automatic test_non_head();
        do_reset();
        do_alloc(1, 7'd10); do_alloc(1, 7'd11);
        do_cmpl(0, 4'd0, 32'h0, 1, 4'd1, 32'h11);
        tick();
        n_total++;
        if (retire_count !== 2'd0 || rob_count !== 5'd2)
            $display("FAIL non_head_hold got rc=%0d cnt=%0d want 0/2", retire_count, rob_count);
        else n_pass++;
        do_cmpl(1, 4'd0, 32'h10, 0, 4'd0, 32'h0);
        tick();
        n_total++;
        if (retire_count !== 2'd2 || {ret_wr_en2, ret_wr_en1} !== 2'b11 ||
            ret_wr_data1 !== 32'h10 || ret_wr_data2 !== 32'h11 ||
            ret_wr_addr1 !== 7'd10 || ret_wr_addr2 !== 7'd11)
            $display("FAIL non_head_pair got rc=%0d en=%b %0d<-%0h %0d<-%0h want 2/11 10<-10 11<-11",
                     retire_count, {ret_wr_en2, ret_wr_en1}, ret_wr_addr1, ret_wr_data1, ret_wr_addr2, ret_wr_data2);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(1, 7'(i + 1));
        do_cmpl(1, 4'd0, 32'h1, 1, 4'd1, 32'h2);
        // Head two are now done and would retire this cycle; flush must win.
        flush = 1; alloc_valid = 1; alloc_dest_en = 1; alloc_rd = 7'd30;
        tick();
        flush = 0; alloc_valid = 0;
        n_total++;
        if (rob_count !== 5'd0 || alloc_idx !== 4'd0 || rob_empty !== 1'b1)
            $display("FAIL flush_state got cnt=%0d idx=%0d emp=%b want 0/0/1", rob_count, alloc_idx, rob_empty);
        else n_pass++;
        n_total++;
        if ({ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b000 || retire_count !== 2'd0)
            $display("FAIL flush_no_retire got en=%b rc=%0d want 000/0", {ret_wr_en3, ret_wr_en2, ret_wr_en1}, retire_count);
        else n_pass++;
        tick();
        n_total++;
        if ({ret_wr_en3, ret_wr_en2, ret_wr_en1} !== 3'b000 || retire_count !== 2'd0 || rob_count !== 5'd0)
            $display("FAIL flush_after got en=%b rc=%0d cnt=%0d want 000/0/0",
                     {ret_wr_en3, ret_wr_en2, ret_wr_en1}, retire_count, rob_count);
        else n_pass++;
        do_alloc(1, 7'd4);
        n_total++;
        if (alloc_idx !== 4'd1 || rob_count !== 5'd1)
            $display("FAIL flush_realloc got idx=%0d cnt=%0d want 1/1", alloc_idx, rob_count);
        else n_pass++;
    endtask

    initial begin
        rstn = 0;
        idle();
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_same_rd();
        test_no_dest();
        test_non_head();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/rob_commit.md
# rob_commit

In-order commit unit for the RISC-V out-of-order core. Holds a 16-entry reorder buffer, allocates one entry per cycle at dispatch, and accepts out-of-order results on two completion ports. Retires up to three completed head entries per cycle in program order, driving the three write ports of the architectural register file.

## Interface
Parameters:
- ROB_DEPTH, 16: number of reorder-buffer entries, power of two.
- ROB_IDX, 4: log2(ROB_DEPTH).
- AR_SIZE, 7: architectural register address width.
- DATA_W, 32: result data width.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  discard all in-flight entries.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_dest_en  in  1  instruction writes a destination register.
- alloc_rd  in  AR_SIZE  destination register.
- alloc_ready  out  1  entry available.
- alloc_idx  out  ROB_IDX  index granted; equals the tail pointer.
- cmpl0_valid / cmpl1_valid  in  1  result valid on completion port 0 / 1.
- cmpl0_idx / cmpl1_idx  in  ROB_IDX  entry being completed.
- cmpl0_data / cmpl1_data  in  DATA_W  result value.
- ret_wr_en1..3  out  1  per-slot register-file write enable; slot 1 is oldest.
- ret_wr_addr1..3  out  AR_SIZE  write address.
- ret_wr_data1..3  out  DATA_W  write data.
- retire_count  out  2  entries retired in the last decision, 0 to 3.
- rob_count  out  ROB_IDX+1  occupied entries.
- rob_empty  out  1  rob_count == 0.

## Operation
- Each entry holds the fields valid, done, dest_en, rd and data. head and tail are ROB_IDX-bit pointers that wrap modulo ROB_DEPTH.
- Allocation:
  - An allocation is accepted when alloc_valid && alloc_ready.
  - The entry at tail is written with valid=1, done=0, dest_en and rd, and tail advances by 1.
  - alloc_ready = (rob_count < ROB_DEPTH) and is computed from registered state only. When the ROB is full, a retire in the same cycle does not free a slot for that cycle's allocation.
- Completion:
  - A completion sets done=1 and writes data.
  - A completion that targets an entry with valid=0 or done=1 is ignored.
  - If both ports target the same index in the same cycle, port 1 wins.
- Retire selection:
  - Selection examines head, head+1 and head+2 using registered valid/done bits only. A completion in the same cycle is not visible until the next cycle.
  - The longest prefix of valid&&done entries is retired, at most 3. Those entries are cleared and head advances by that count.
- Retire write enables:
  - ret_wr_enN = dest_en && (rd != 0). Entries with no destination and writes to x0 still retire, but with the enable at 0.
  - If two retiring slots share an rd, the older slot's enable is suppressed so that the youngest write wins. This applies across all three slots.
  - Unused slots drive en=0; address and data are don't-care.
- Occupancy: rob_count_next = rob_count + accepted_alloc − retired.
- Flush:
  - At the next edge, all valid bits are cleared, head = tail = 0, rob_count = 0, all ret_wr_en = 0 and retire_count = 0.
  - Flush has priority over alloc, completion and retire in the same cycle.
- Reset (rstn=0 at an edge) has the same effect as flush. In addition, all ret_wr_addr, ret_wr_data and entry data are set to 0. A reset mid-operation drops every in-flight entry with no retire.

## Timing
- Reset values: alloc_ready=1, alloc_idx=0, ret_wr_en1..3=0, ret_wr_addr1..3=0, ret_wr_data1..3=0, retire_count=0, rob_count=0, rob_empty=1.
- The ret_wr_* outputs and retire_count are registered. They are updated at the same edge at which head advances and are held for exactly one cycle.
- Completion-to-write latency: completion sampled at edge E → retire decided in the cycle after E → ret_wr_* valid after edge E+1 (2 edges).
- Allocation-to-retire minimum: alloc at E0, complete at E1, write visible after E2.
- alloc_idx and alloc_ready are stable throughout the cycle; they change only at an edge.

## Structure
- Shared package rob_pkg:
  - rob_entry_t struct (valid, done, dest_en, rd, data).
  - Constants ROB_DEPTH, ROB_IDX, RETIRE_W=3.
  - AR_SIZE and DATA_W are shared with the register-file package.
- Sub-module rob_retire_sel: purely combinational. It takes the three head entries and produces the retire count, the per-slot enables with duplicate-rd suppression, and the per-slot addresses and data.
- The top level holds the entry array, the pointers, the counter, and the output registers.

## Test plan
- Reset, then allocate 3 entries (rd=5,6,7) and complete them in the order 2,0,1 with data 0xA,0xB,0xC. Required: a single retire with retire_count=3; writes 5←0xB, 6←0xC, 7←0xA; rob_empty=1.
- Fill all 16 entries. Required: alloc_ready=0 and a request on the next cycle is not accepted. Complete the head entry; after the retire, alloc_ready=1 and alloc_idx=0 (wrap-around).
- Retire three entries that all target rd=3, with data 1,2,3. Required: only ret_wr_en3=1, with data 3.
- Allocate an entry with alloc_dest_en=0 and an entry with rd=0, then complete both. Required: retire_count=2 with all ret_wr_en=0.
- Complete a non-head entry only. Required: no retire. Then complete the head. Required: both retire in one cycle.
- Assert flush with 5 entries in flight, 2 of them done, and an alloc in the same cycle. Required: at the next edge rob_count=0, alloc_idx=0, and no ret_wr_en assertion.
